// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, access sizes and
// read/write encodings. The size-to-beat-count mapping is also kept here.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BEAT  = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_1  = 2'b00;
    localparam logic [1:0] SIZE_4  = 2'b01;
    localparam logic [1:0] SIZE_8  = 2'b10;
    localparam logic [1:0] SIZE_16 = 2'b11;

    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;

    function automatic logic [4:0] size_beats(input logic [1:0] size);
        case (size)
            SIZE_1:  return 5'd1;
            SIZE_4:  return 5'd4;
            SIZE_8:  return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between data and fetch ports; combinational, data wins ties.
// With MEM_ARB_STARVE_GUARD_EN a loss counter lets fetch win after STARVE_LIMIT contested losses.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
`ifdef MEM_ARB_STARVE_GUARD_EN
    input  logic clock,
    input  logic reset,
    input  logic arb_en,
`endif
    input  logic i_req,
    input  logic d_req,
    output logic sel_i,
    output logic sel_d
);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("mem_arb_prio: STARVE_LIMIT must be at least 1");
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             force_i;

    always_comb begin
        force_i  = (starve_q >= CNT_W'(STARVE_LIMIT));
        sel_i    = i_req & (~d_req | force_i);
        sel_d    = d_req & ~sel_i;
        starve_d = starve_q;
        // Only arbitrations that fetch actually takes part in move the counter.
        if (arb_en && i_req) begin
            if (sel_i) begin
                starve_d = '0;
            end else begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    always_comb begin
        sel_d = d_req;
        sel_i = i_req & ~d_req;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one memory; ISSUE one cycle after a req, beats follow
// each non-busy cycle, all outputs registered. Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [1:0]            i_size,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_rw,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [1:0]            d_size,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_wack,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic [1:0]            access_size,
    output logic                  rw,
    output logic                  enable,
    input  logic                  busy,
    input  logic [DATA_WIDTH-1:0] data_out
);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~(ADDR_WIDTH'(3));

    state_t                state_q, state_d;
    logic                  own_data_q, own_data_d;
    logic [4:0]            beats_q, beats_d;
    logic                  enable_q, enable_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
    logic [1:0]            access_size_q, access_size_d;
    logic                  i_gnt_q, i_gnt_d;
    logic                  i_rvalid_q, i_rvalid_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic                  d_gnt_q, d_gnt_d;
    logic                  d_rvalid_q, d_rvalid_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  d_wack_q, d_wack_d;
    logic                  sel_i, sel_d;

    mem_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
`ifdef MEM_ARB_STARVE_GUARD_EN
        .clock (clock),
        .reset (reset),
        .arb_en(state_q == IDLE),
`endif
        .i_req (i_req),
        .d_req (d_req),
        .sel_i (sel_i),
        .sel_d (sel_d)
    );

    always_comb begin
        state_d       = state_q;
        own_data_d    = own_data_q;
        beats_d       = beats_q;
        rw_d          = rw_q;
        address_d     = address_q;
        data_in_d     = data_in_q;
        access_size_d = access_size_q;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        enable_d      = 1'b0;
        i_gnt_d       = 1'b0;
        d_gnt_d       = 1'b0;
        i_rvalid_d    = 1'b0;
        d_rvalid_d    = 1'b0;
        d_wack_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sel_d) begin
                    own_data_d    = 1'b1;
                    rw_d          = d_rw;
                    address_d     = d_addr & WORD_MASK;
                    data_in_d     = (d_rw == MEM_WR) ? d_wdata : '0;
                    access_size_d = (d_rw == MEM_WR) ? SIZE_1 : d_size;
                    beats_d       = size_beats(access_size_d);
                    d_gnt_d       = 1'b1;
                    enable_d      = 1'b1;
                    state_d       = ISSUE;
                end else if (sel_i) begin
                    own_data_d    = 1'b0;
                    rw_d          = MEM_RD;
                    address_d     = i_addr & WORD_MASK;
                    data_in_d     = '0;
                    access_size_d = i_size;
                    beats_d       = size_beats(i_size);
                    i_gnt_d       = 1'b1;
                    enable_d      = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                state_d = BEAT;
            end
            BEAT: begin
                // A busy cycle is simply a non-event: the remaining count holds.
                if (!busy) begin
                    if (rw_q == MEM_RD) begin
                        if (own_data_q) begin
                            d_rvalid_d = 1'b1;
                            d_rdata_d  = data_out;
                        end else begin
                            i_rvalid_d = 1'b1;
                            i_rdata_d  = data_out;
                        end
                        beats_d = beats_q - 5'd1;
                        if (beats_q == 5'd1) begin
                            state_d = IDLE;
                        end
                    end else begin
                        d_wack_d = 1'b1;
                        beats_d  = '0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            own_data_q    <= 1'b0;
            beats_q       <= '0;
            enable_q      <= 1'b0;
            rw_q          <= 1'b0;
            address_q     <= '0;
            data_in_q     <= '0;
            access_size_q <= SIZE_1;
            i_gnt_q       <= 1'b0;
            i_rvalid_q    <= 1'b0;
            i_rdata_q     <= '0;
            d_gnt_q       <= 1'b0;
            d_rvalid_q    <= 1'b0;
            d_rdata_q     <= '0;
            d_wack_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            own_data_q    <= own_data_d;
            beats_q       <= beats_d;
            enable_q      <= enable_d;
            rw_q          <= rw_d;
            address_q     <= address_d;
            data_in_q     <= data_in_d;
            access_size_q <= access_size_d;
            i_gnt_q       <= i_gnt_d;
            i_rvalid_q    <= i_rvalid_d;
            i_rdata_q     <= i_rdata_d;
            d_gnt_q       <= d_gnt_d;
            d_rvalid_q    <= d_rvalid_d;
            d_rdata_q     <= d_rdata_d;
            d_wack_q      <= d_wack_d;
        end
    end

    assign enable      = enable_q;
    assign rw          = rw_q;
    assign address     = address_q;
    assign data_in     = data_in_q;
    assign access_size = access_size_q;
    assign i_gnt       = i_gnt_q;
    assign i_rvalid    = i_rvalid_q;
    assign i_rdata     = i_rdata_q;
    assign d_gnt       = d_gnt_q;
    assign d_rvalid    = d_rvalid_q;
    assign d_rdata     = d_rdata_q;
    assign d_wack      = d_wack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requesters and memory are modelled at transaction level;
// every negedge the outputs are compared with what the arbitration and beat rules predict.
module tb_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          i_req, i_gnt, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [1:0]    i_size;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_rw, d_gnt, d_rvalid, d_wack;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [1:0]    d_size;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in, data_out;
    logic [1:0]    access_size;
    logic          rw, enable, busy;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_size(i_size),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_wack(d_wack),
        .address(address), .data_in(data_in), .access_size(access_size), .rw(rw),
        .enable(enable), .busy(busy), .data_out(data_out)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction-level model state
    int      beats_of[4] = '{1, 4, 8, 16};
    bit      beat_active = 0, issue_pending = 0, idle_prev = 0;
    bit      own_data = 0, own_rd = 0;
    int      beats_left = 0, losses = 0;
    logic [AW-1:0] issue_addr = '0;
    logic [DW-1:0] wr_data_seen = '0;
    // Stimulus controls and event bookkeeping
    bit      hold_reqs = 0, rand_req = 0, rand_busy = 0;
    bit      busy_script[$];
    int      cyc = 0, n_i_rv = 0, n_d_rv = 0, n_i_gnt = 0, n_d_gnt = 0;
    int      d_gnts_at_first_i = -1, i_gnt_cyc = 0, d_gnt_cyc = 0, wack_cyc = 0;

    task automatic cycle();
        bit exp_irv, exp_drv, exp_wack, exp_issue, data_wins;
        logic [1:0] exp_size;
        @(negedge clock);
        cyc++;
        if (i_rvalid) n_i_rv++;
        if (d_rvalid) n_d_rv++;
        if (i_gnt) begin
            if (n_i_gnt == 0) d_gnts_at_first_i = n_d_gnt;
            n_i_gnt++;
            i_gnt_cyc = cyc;
        end
        if (d_gnt) begin n_d_gnt++; d_gnt_cyc = cyc; end
        if (d_wack) wack_cyc = cyc;

        if (reset) begin
            check("rst_ctrl", {enable, rw, i_gnt, i_rvalid, d_gnt, d_rvalid, d_wack, access_size}, 0);
            check("rst_address", address, 0);
            check("rst_data_in", data_in, 0);
            check("rst_rdata", {i_rdata, d_rdata}, 0);
            beat_active = 0; issue_pending = 0; losses = 0; beats_left = 0;
        end else begin
            exp_irv = 0; exp_drv = 0; exp_wack = 0;
            // The posedge just passed consumed a beat if we were in the beat phase and memory was free.
            if (beat_active && !busy) begin
                if (own_rd) begin
                    if (own_data) exp_drv = 1; else exp_irv = 1;
                    beats_left--;
                end else begin
                    exp_wack = 1;
                    beats_left = 0;
                end
                if (beats_left == 0) beat_active = 0;
            end
            check("i_rvalid", i_rvalid, exp_irv);
            check("d_rvalid", d_rvalid, exp_drv);
            check("d_wack", d_wack, exp_wack);
            if (exp_irv) check("i_rdata", i_rdata, data_out);
            if (exp_drv) check("d_rdata", d_rdata, data_out);
            if (issue_pending) begin beat_active = 1; issue_pending = 0; end
            if (beat_active) check("hold_address", address, issue_addr);

            exp_issue = idle_prev && (i_req || d_req);
            check("enable", enable, exp_issue);
            if (exp_issue) begin
                data_wins = d_req && !(i_req && GUARD && losses >= LIMIT);
                check("grant", {d_gnt, i_gnt}, {data_wins, !data_wins});
                own_data   = data_wins;
                own_rd     = data_wins ? d_rw : 1'b1;
                exp_size   = !own_rd ? 2'b00 : (data_wins ? d_size : i_size);
                issue_addr = (data_wins ? d_addr : i_addr) & ~32'h3;
                check("address", address, issue_addr);
                check("rw", rw, own_rd);
                check("access_size", access_size, exp_size);
                if (!own_rd) begin
                    check("data_in", data_in, d_wdata);
                    wr_data_seen = data_in;
                end
                beats_left = own_rd ? beats_of[exp_size] : 1;
                if (data_wins && i_req) losses++;
                else if (!data_wins) losses = 0;
                issue_pending = 1;
            end else begin
                check("grant_idle", {d_gnt, i_gnt}, 2'b00);
            end
        end
        idle_prev = !beat_active && !issue_pending;

        // Requesters drop req once granted, then may raise a new one
        if (i_gnt && !hold_reqs) i_req = 0;
        if (d_gnt && !hold_reqs) d_req = 0;
        if (rand_req) begin
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_addr = $urandom; i_size = 2'($urandom_range(0, 3));
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_rw = 1'($urandom_range(0, 1)); d_addr = $urandom;
                d_wdata = $urandom; d_size = 2'($urandom_range(0, 3));
            end
        end
        if (busy_script.size() > 0) busy = busy_script.pop_front();
        else busy = rand_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
        data_out = $urandom;
    endtask

    task automatic run_until_idle(input string tag, input int max);
        int k = 0;
        while ((i_req || d_req || !idle_prev) && k < max) begin
            cycle();
            k++;
        end
        check({tag, "_completed"}, k < max, 1);
    endtask

    task automatic apply_reset();
        reset = 1;
        repeat (2) cycle();
        reset = 0;
    endtask

    task automatic clear_counts();
        n_i_rv = 0; n_d_rv = 0; n_i_gnt = 0; n_d_gnt = 0; d_gnts_at_first_i = -1;
    endtask

    initial begin
        reset = 1; i_req = 0; i_addr = '0; i_size = 0;
        d_req = 0; d_rw = 0; d_addr = '0; d_wdata = '0; d_size = 0;
        busy = 0; data_out = '0;
        apply_reset();

        // Single-word fetch
        clear_counts();
        i_req = 1; i_addr = 32'h8002_0000; i_size = 2'b00;
        run_until_idle("fetch1", 20);
        check("fetch1_addr", issue_addr, 32'h8002_0000);
        check("fetch1_gnts", n_i_gnt, 1);
        check("fetch1_beats", n_i_rv, 1);

        // Simultaneous write and fetch: data first, fetch right after the turnaround cycle
        clear_counts();
        i_req = 1; i_addr = 32'h8002_0100; i_size = 2'b00;
        d_req = 1; d_rw = 0; d_addr = 32'h8002_0010; d_wdata = 32'hDEAD_BEEF; d_size = 2'b11;
        run_until_idle("wr_fetch", 30);
        check("wr_data_in", wr_data_seen, 32'hDEAD_BEEF);
        check("wr_before_fetch", d_gnt_cyc < i_gnt_cyc, 1);
        check("fetch_after_idle", i_gnt_cyc - wack_cyc, 1);

        // Four-beat fetch with memory busy for three cycles mid-burst
        clear_counts();
        busy_script = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        i_req = 1; i_addr = 32'h8002_0203; i_size = 2'b01;
        run_until_idle("burst4", 30);
        check("burst4_beats", n_i_rv, 4);

        // Both ports requesting continuously
        apply_reset();
        clear_counts();
        hold_reqs = 1;
        d_req = 1; d_rw = 0; d_addr = 32'h0000_1000; d_wdata = 32'h1234_5678;
        i_req = 1; i_addr = 32'h0000_2000; i_size = 2'b00;
        repeat (60) cycle();
`ifdef MEM_ARB_STARVE_GUARD_EN
        check("starve_fetch_won", n_i_gnt > 0, 1);
        check("starve_data_wins_first", d_gnts_at_first_i, LIMIT);
`else
        check("strict_fetch_starved", n_i_gnt, 0);
`endif
        hold_reqs = 0; d_req = 0; i_req = 0;
        run_until_idle("hold_drain", 40);

        // Reset during a 16-beat fetch
        clear_counts();
        i_req = 1; i_addr = 32'h8002_0400; i_size = 2'b11;
        for (int k = 0; k < 40 && n_i_rv < 3; k++) cycle();
        check("rst_mid_reached", n_i_rv, 3);
        reset = 1;
        cycle();
        reset = 0;
        repeat (20) cycle();
        check("rst_mid_no_more_beats", n_i_rv, 3);

        // Randomized traffic
        rand_req = 1; rand_busy = 1;
        repeat (1500) cycle();
        rand_req = 0;
        run_until_idle("random", 300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, memory address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, memory data width in bits.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive fetch losses before fetch is forced to win.
REQ-004 Port clock  in  1  single clock; all logic on the rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Ports i_req/i_addr/i_size  in  1/ADDR_WIDTH/2  fetch port; read-only request, address, access_size.
REQ-007 Ports i_gnt/i_rvalid/i_rdata  out  1/1/DATA_WIDTH  fetch grant pulse, read-beat valid, read data.
REQ-008 Ports d_req/d_rw/d_addr/d_wdata/d_size  in  1/1/ADDR_WIDTH/DATA_WIDTH/2  data port; rw=1 read, rw=0 write.
REQ-009 Ports d_gnt/d_rvalid/d_rdata/d_wack  out  1/1/DATA_WIDTH/1  data grant pulse, read-beat valid, read data, write-done pulse.
REQ-010 Ports address/data_in/access_size/rw/enable  out  ADDR_WIDTH/DATA_WIDTH/2/1/1  drive the shared memory.
REQ-011 Ports busy/data_out  in  1/DATA_WIDTH  from the shared memory.

Function
REQ-012 FSM states IDLE, ISSUE, BEAT; all outputs registered.
REQ-013 IDLE: if any req is high, latch the winner's command, go to ISSUE next cycle; else stay in IDLE with enable=0.
REQ-014 Priority: data port wins over fetch when both req high in the same IDLE cycle.
REQ-015 ISSUE (exactly one cycle): enable=1, memory command driven from the latched request, winner's gnt=1 for that cycle only; next state BEAT.
REQ-016 Requesters hold req and command stable until gnt; arbiter ignores command changes after latching.
REQ-017 Beat count from size: 00=1, 01=4, 10=8, 11=16 words.
REQ-018 BEAT read: each cycle with busy=0, drive winner's rvalid=1 and rdata=data_out; after the final beat, go to IDLE.
REQ-019 BEAT read: a cycle with busy=1 produces no beat; the beat counter holds.
REQ-020 Write: size is forced to 00; first BEAT cycle with busy=0 pulses d_wack, then IDLE.
REQ-021 Arbiter never increments address; memory sequences burst addresses; addr[1:0] forced to 00 on output.
REQ-022 enable deasserts in BEAT; address/rw/access_size hold latched values until IDLE.
REQ-023 Minimum turnaround: one IDLE cycle between consecutive transactions; new req seen in that cycle is arbitrated normally.
REQ-024 Non-winning req stays pending, unacknowledged, with no side effects.

Reset
REQ-025 Reset forces IDLE; enable, rw, all gnt/rvalid/wack = 0; address, data_in, rdata buses = 0; access_size = 00; beat and starve counters = 0.
REQ-026 Reset mid-transaction abandons it with no further rvalid/wack; requester re-requests.

Configuration
REQ-027 Macro MEM_ARB_STARVE_GUARD_EN defined: 3-bit-or-wider counter increments each IDLE arbitration fetch loses while i_req=1, clears when fetch wins; when count = STARVE_LIMIT, fetch wins the next contested arbitration.
REQ-028 Macro undefined: strict data-over-fetch priority, no counter in the netlist.

Structure
REQ-029 Package mem_arb_pkg: state enum, size encodings, MEM_RD=1/MEM_WR=0 constants, function size-to-beat-count.
REQ-030 One sub-module mem_arb_prio: combinational winner select plus starvation counter (counter only under MEM_ARB_STARVE_GUARD_EN).

Verification
REQ-031 i_req, i_addr=0x80020000, size 00, busy=0 -> ISSUE one cycle after req with address=0x80020000, rw=1, enable=1, i_gnt=1; one i_rvalid the next cycle with data_out.
REQ-032 i_req and d_req (rw=0, addr 0x80020010, wdata 0xDEADBEEF) same cycle -> d_gnt first, data_in=0xDEADBEEF, d_wack; i_gnt only after a following IDLE cycle.
REQ-033 Fetch size 01 with busy high on 2nd beat for 3 cycles -> exactly 4 i_rvalid pulses, none while busy=1, then IDLE.
REQ-034 Define MEM_ARB_STARVE_GUARD_EN, hold d_req and i_req continuously -> fetch granted after 4 data grants; macro undefined -> fetch never granted.
REQ-035 Assert reset during BEAT of a size-11 read -> next cycle all outputs at reset values, no further i_rvalid.
